// File: rtl/rcb_port_arb.sv
// Single-port RAM arbiter: strategy reads always win, host writes wait in a FIFO.
// Reads forward the newest queued write to the same address.
module rcb_port_arb #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 128,
    parameter int WQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sef_rd,
    input  logic [ADDR_WIDTH-1:0]         sef_rd_addr,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          hpb_wr_valid,
    output logic                          hpb_wr_ready,
    input  logic [ADDR_WIDTH-1:0]         hpb_wr_addr,
    input  logic [DATA_WIDTH-1:0]         hpb_wr_data,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata,
    output logic [$clog2(WQ_DEPTH):0]     wq_count,
    output logic                          starve_evt
);

    localparam int PW = $clog2(WQ_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addr_q [WQ_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [WQ_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [7:0]            blk_cnt;
    logic                  fwd_hit_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic [DATA_WIDTH-1:0] rd_hold;

    logic                  q_nonempty;
    logic                  push;
    logic                  pop;
    logic                  blocked;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PW-1:0]         idx;

    assign q_nonempty   = (count != '0);
    assign hpb_wr_ready = (count < CW'(WQ_DEPTH));
    assign push         = hpb_wr_valid && hpb_wr_ready;
    assign pop          = reset_n && !sef_rd && q_nonempty;
    assign blocked      = sef_rd && q_nonempty;
    assign wq_count     = count;

    // RAM port mux: reads take the port, otherwise drain the queue head
    always_comb begin
        ram_en    = reset_n && (sef_rd || q_nonempty);
        ram_we    = pop;
        ram_addr  = sef_rd ? sef_rd_addr : addr_q[rd_ptr];
        ram_wdata = data_q[rd_ptr];
    end

    // Newest occupied queue entry matching the read address
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count && addr_q[idx] == sef_rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    // Queue storage, written on accept
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= hpb_wr_addr;
            data_q[wr_ptr] <= hpb_wr_data;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Read pipeline: valid and forward capture one cycle after the strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid   <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            rd_hold    <= '0;
        end else begin
            rd_valid <= sef_rd;
            if (sef_rd) begin
                fwd_hit_q  <= fwd_hit;
                fwd_data_q <= fwd_data;
            end
            if (rd_valid)
                rd_hold <= rd_data;
        end
    end

    // Read data: forwarded or RAM while valid, held value otherwise
    always_comb begin
        if (rd_valid)
            rd_data = fwd_hit_q ? fwd_data_q : ram_rdata;
        else
            rd_data = rd_hold;
    end

    // Starvation counter and single-cycle event on reaching the limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt    <= '0;
            starve_evt <= 1'b0;
        end else begin
            starve_evt <= blocked && (blk_cnt == 8'(STARVE_LIMIT - 1));
            if (!blocked)
                blk_cnt <= '0;
            else if (blk_cnt != 8'hFF)
                blk_cnt <= blk_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rcb_port_arb.sv
// Randomized bench for rcb_port_arb with a queue-based reference model.
// Read expectations flow through a scoreboard checked by a separate monitor.
module tb_rcb_port_arb;

    localparam int AW    = 6;
    localparam int DW    = 128;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sef_rd;
    logic [AW-1:0] sef_rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          hpb_wr_valid;
    logic          hpb_wr_ready;
    logic [AW-1:0] hpb_wr_addr;
    logic [DW-1:0] hpb_wr_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [CW-1:0] wq_count;
    logic          starve_evt;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem     [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    ent_t          mq[$];
    logic [DW-1:0] rd_exp[$];
    int            blk_run;
    logic          exp_starve;
    logic          prev_rd;
    int            starve_seen;

    rcb_port_arb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .WQ_DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sef_rd(sef_rd),
        .sef_rd_addr(sef_rd_addr),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .hpb_wr_valid(hpb_wr_valid),
        .hpb_wr_ready(hpb_wr_ready),
        .hpb_wr_addr(hpb_wr_addr),
        .hpb_wr_data(hpb_wr_data),
        .ram_en(ram_en),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .wq_count(wq_count),
        .starve_evt(starve_evt)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                mem[ram_addr] <= ram_wdata;
            else
                ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: evaluates each cycle's inputs against the rules
    initial begin
        int prev;
        int nv;
        logic [DW-1:0] e;
        blk_run    = 0;
        exp_starve = 1'b0;
        prev_rd    = 1'b0;
        starve_seen = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_ram_en", DW'(ram_en), '0);
                chk("rst_ram_we", DW'(ram_we), '0);
                chk("rst_rd_valid", DW'(rd_valid), '0);
                chk("rst_wq_count", DW'(wq_count), '0);
                chk("rst_starve", DW'(starve_evt), '0);
                chk("rst_rd_data", rd_data, '0);
                mq.delete();
                rd_exp.delete();
                blk_run    = 0;
                exp_starve = 1'b0;
                prev_rd    = 1'b0;
                continue;
            end
            chk("wq_count", DW'(wq_count), DW'(mq.size()));
            chk("wr_ready", DW'(hpb_wr_ready), DW'(mq.size() < DEPTH));
            chk("rd_valid", DW'(rd_valid), DW'(prev_rd));
            chk("starve_evt", DW'(starve_evt), DW'(exp_starve));
            if (starve_evt)
                starve_seen++;
            if (sef_rd) begin
                chk("rd_ram_en", DW'(ram_en), 1);
                chk("rd_ram_we", DW'(ram_we), 0);
                chk("rd_ram_addr", DW'(ram_addr), DW'(sef_rd_addr));
                e = ref_mem[sef_rd_addr];
                foreach (mq[i])
                    if (mq[i].a == sef_rd_addr)
                        e = mq[i].d;
                rd_exp.push_back(e);
            end else if (mq.size() > 0) begin
                chk("wr_ram_en", DW'(ram_en), 1);
                chk("wr_ram_we", DW'(ram_we), 1);
                chk("wr_ram_addr", DW'(ram_addr), DW'(mq[0].a));
                chk("wr_ram_wdata", ram_wdata, mq[0].d);
                ref_mem[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
            end else begin
                chk("idle_ram_en", DW'(ram_en), 0);
                chk("idle_ram_we", DW'(ram_we), 0);
            end
            if (hpb_wr_valid && (wq_count < CW'(DEPTH)))
                mq.push_back('{a: hpb_wr_addr, d: hpb_wr_data});
            if (sef_rd && wq_count != '0) begin
                prev = blk_run;
                nv = (prev < 255) ? prev + 1 : 255;
                blk_run = nv;
                exp_starve = (nv == LIMIT) && (prev != LIMIT);
            end else begin
                blk_run = 0;
                exp_starve = 1'b0;
            end
            prev_rd = sef_rd;
        end
    end

    // Read monitor: pops the scoreboard whenever the DUT presents data
    initial begin
        logic [DW-1:0] last;
        logic [DW-1:0] e;
        last = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                last = '0;
            end else if (rd_valid) begin
                if (rd_exp.size() == 0) begin
                    chk("rd_unexpected", DW'(rd_valid), 0);
                end else begin
                    e = rd_exp.pop_front();
                    chk("rd_data", rd_data, e);
                    last = e;
                end
            end else begin
                chk("rd_hold", rd_data, last);
            end
        end
    end

    task automatic drive(input int rd_pct, input int wr_pct, input int amax);
        @(posedge clk);
        #1;
        sef_rd       = ($urandom_range(0, 99) < rd_pct);
        sef_rd_addr  = AW'($urandom_range(0, amax));
        hpb_wr_valid = ($urandom_range(0, 99) < wr_pct);
        hpb_wr_addr  = AW'($urandom_range(0, amax));
        hpb_wr_data  = rnd_data();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = rnd_data();
            ref_mem[i] = mem[i];
        end
        reset_n      = 1'b0;
        sef_rd       = 1'b1;
        sef_rd_addr  = '0;
        hpb_wr_valid = 1'b0;
        hpb_wr_addr  = '0;
        hpb_wr_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        sef_rd  = 1'b0;
        for (int c = 0; c < 800; c++)
            drive(30, 50, 7);
        for (int c = 0; c < 800; c++)
            drive(90, 70, 3);
        // long blocked stretch: counter saturates, only one event
        for (int c = 0; c < 300; c++)
            drive(100, 60, 15);
        for (int c = 0; c < 20; c++)
            drive(0, 0, 7);
        // reset with writes pending and a read in flight
        for (int c = 0; c < 6; c++)
            drive(100, 100, 7);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sef_rd = 1'b0;
        hpb_wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 800; c++)
            drive(60, 60, 5);
        for (int c = 0; c < 10; c++)
            drive(0, 0, 7);
        @(negedge clk);
        #2;
        chk("scoreboard_empty", DW'(rd_exp.size()), 0);
        checks++;
        if (starve_seen == 0) begin
            failures++;
            $display("FAIL starve_seen: got %0d expected nonzero", starve_seen);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rcb_port_arb.md
RCB_PORT_ARB -- requirements
Module: rcb_port_arb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 14, RAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 128, RAM word width.
REQ-003 The block SHALL have parameter WQ_DEPTH, default 4, host write queue entries (power of 2, >=2).
REQ-004 The block SHALL have parameter STARVE_LIMIT, default 8, consecutive blocked cycles that raise starve_evt (1..255).
REQ-005 The block SHALL have port clk, input, 1, the only clock; all state is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port sef_rd, input, 1, strategy read strobe.
REQ-008 The block SHALL have port sef_rd_addr, input, ADDR_WIDTH, strategy read address.
REQ-009 The block SHALL have port rd_valid, output, 1, read data valid.
REQ-010 The block SHALL have port rd_data, output, DATA_WIDTH, read data.
REQ-011 The block SHALL have port hpb_wr_valid, input, 1, host write request.
REQ-012 The block SHALL have port hpb_wr_ready, output, 1, host write accept.
REQ-013 The block SHALL have ports hpb_wr_addr, input, ADDR_WIDTH, and hpb_wr_data, input, DATA_WIDTH, host write address and data.
REQ-014 The block SHALL have ports ram_en, output, 1; ram_we, output, 1; ram_addr, output, ADDR_WIDTH; and ram_wdata, output, DATA_WIDTH, which drive the single-port RAM.
REQ-015 The block SHALL have port ram_rdata, input, DATA_WIDTH, RAM read data, valid 1 cycle after a read enable.
REQ-016 The block SHALL have port wq_count, output, $clog2(WQ_DEPTH)+1, number of queued writes.
REQ-017 The block SHALL have port starve_evt, output, 1, one-cycle starvation pulse.

Function
REQ-018 Strategy reads SHALL have absolute priority: in any cycle with sef_rd=1, the RAM outputs SHALL be combinationally driven as ram_en=1, ram_we=0, ram_addr=sef_rd_addr.
REQ-019 In a cycle with sef_rd=0 and wq_count>0, the RAM outputs SHALL be ram_en=1, ram_we=1, with ram_addr and ram_wdata taken from the queue head, and the head SHALL pop at that clock edge.
REQ-020 In a cycle with sef_rd=0 and an empty queue, ram_en SHALL be 0 and ram_we SHALL be 0.
REQ-021 hpb_wr_ready SHALL equal (wq_count < WQ_DEPTH), derived from registered count only; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-022 A host write SHALL be enqueued at the edge where hpb_wr_valid and hpb_wr_ready are both 1; the queue SHALL be FIFO ordered.
REQ-023 A simultaneous enqueue and pop SHALL leave wq_count unchanged; pointers SHALL wrap modulo WQ_DEPTH.
REQ-024 rd_valid SHALL be 1 exactly one cycle after each sef_rd=1 cycle (latency 1), and 0 otherwise; back-to-back reads SHALL give back-to-back rd_valid.
REQ-025 Read forwarding: at the sef_rd cycle, sef_rd_addr SHALL be compared against all occupied queue entries; if any match, rd_data SHALL be the data of the newest matching entry, otherwise ram_rdata.
REQ-026 A write accepted in the same cycle as a read SHALL NOT be visible to that read.
REQ-027 When rd_valid=0, rd_data SHALL hold its last value.
REQ-028 The block SHALL keep an 8-bit saturating counter of consecutive cycles with sef_rd=1 and wq_count>0; the counter SHALL clear on any other cycle.
REQ-029 starve_evt SHALL pulse for one cycle on the edge where the starvation counter becomes STARVE_LIMIT.
REQ-030 Writes SHALL never preempt reads, and no request SHALL ever be dropped.

Reset
REQ-031 While reset_n=0, the block SHALL asynchronously clear queue pointers, wq_count, the starvation counter, rd_valid, starve_evt, and rd_data to 0.
REQ-032 Pending writes SHALL be discarded on reset, and a read in flight SHALL produce no rd_valid.
REQ-033 hpb_wr_ready SHALL be 1 after reset release.
REQ-034 During reset, ram_en and ram_we SHALL be 0 regardless of sef_rd.

Verification
REQ-035 Write then read, no contention: write A=0x10 D=0xAA, then a read of 0x10 two cycles later -> ram_we pulse at 0x10; rd_valid+1 cycle, rd_data=0xAA.
REQ-036 Forwarding: continuous sef_rd for 10 cycles while writing 0x10 with D=1 then D=2 -> no RAM write occurs; a read of 0x10 issued after both accepts returns 2; wq_count=2.
REQ-037 Full queue: 5 writes with sef_rd held high -> 4 accepted, hpb_wr_ready=0 on the 5th; release sef_rd -> 4 writes drain FIFO order in 4 cycles; the 5th write is accepted and written after.
REQ-038 Starvation: 1 queued write with sef_rd held high -> starve_evt single pulse on the 8th blocked cycle; no further pulse while the counter saturates; the counter clears when sef_rd drops.
REQ-039 Same-cycle read and enqueue to address 0x20 with RAM holding 0x55 -> rd_data=0x55; a later read returns the new data.
REQ-040 Reset mid-operation: reset with 3 queued writes and a read issued the prior cycle -> wq_count=0, rd_valid=0, no RAM writes after release.
